// File: rtl/axil_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : axil_master_bridge
//  Description : Single-outstanding AXI4-Lite master. Accepts one read or
//                write command on a valid/ready port, runs the AXI4-Lite
//                transaction, and returns read data / response on a
//                separate valid/ready response port.
//  Ports       : clk, rst                  - clock, synchronous active-high reset
//                cmd_*                     - command channel (valid/ready)
//                rsp_*                     - response channel (valid/ready)
//                m_axil_aw*/w*/b*/ar*/r*   - AXI4-Lite master interface
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_master_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  input  logic [2:0]            cmd_prot,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  // AXI4-Lite write address
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  // AXI4-Lite write data
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  // AXI4-Lite write response
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  // AXI4-Lite read address
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  // AXI4-Lite read data
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            prot_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  awvalid_q, wvalid_q, arvalid_q;
  logic                  aw_done_q, w_done_q, b_done_q, ar_done_q, r_done_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_resp_q;

  logic                  w_cmd_fire;
  logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic                  w_wr_complete, w_rd_complete;

  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_aw_hs    = awvalid_q && m_axil_awready;
  assign w_w_hs     = wvalid_q && m_axil_wready;
  assign w_b_hs     = m_axil_bready && m_axil_bvalid;
  assign w_ar_hs    = arvalid_q && m_axil_arready;
  assign w_r_hs     = m_axil_rready && m_axil_rvalid;

  // Handshakes completing this cycle count alongside the sticky flags, so a
  // slave answering AW, W and B together still finishes in a single cycle.
  assign w_wr_complete = (aw_done_q || w_aw_hs) && (w_done_q || w_w_hs) && (b_done_q || w_b_hs);
  assign w_rd_complete = (ar_done_q || w_ar_hs) && (r_done_q || w_r_hs);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid)     state_d = cmd_write ? S_WRITE : S_READ;
      S_WRITE: if (w_wr_complete) state_d = S_RESP;
      S_READ:  if (w_rd_complete) state_d = S_RESP;
      S_RESP:  if (rsp_ready)     state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    m_axil_bready = 1'b0;
    m_axil_rready = 1'b0;
    case (state_q)
      S_IDLE:  cmd_ready     = 1'b1;
      S_WRITE: m_axil_bready = 1'b1;
      S_READ:  m_axil_rready = 1'b1;
      S_RESP:  rsp_valid     = 1'b1;
      default: ;
    endcase
  end

  // Command capture, AXI valid tracking and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      prot_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      ar_done_q   <= 1'b0;
      r_done_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_cmd_fire) begin
            addr_q    <= cmd_addr;
            prot_q    <= cmd_prot;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            awvalid_q <= cmd_write;
            wvalid_q  <= cmd_write;
            arvalid_q <= !cmd_write;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
            r_done_q  <= 1'b0;
            // Writes return all-zero read data.
            if (cmd_write) begin
              rsp_rdata_q <= '0;
            end
          end
        end
        S_WRITE: begin
          if (w_aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (w_b_hs) begin
            b_done_q   <= 1'b1;
            rsp_resp_q <= m_axil_bresp;
          end
        end
        S_READ: begin
          if (w_ar_hs) begin
            arvalid_q <= 1'b0;
            ar_done_q <= 1'b1;
          end
          if (w_r_hs) begin
            r_done_q    <= 1'b1;
            rsp_rdata_q <= m_axil_rdata;
            rsp_resp_q  <= m_axil_rresp;
          end
        end
        default: ;
      endcase
    end
  end

  // AW and AR share the captured address/prot; only one valid is ever raised.
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = prot_q;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = prot_q;
  assign m_axil_arvalid = arvalid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_master_bridge
//  Description : Self-checking bench for axil_master_bridge with a
//                configurable-latency AXI4-Lite slave RAM and a word-array
//                reference model of memory contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_master_bridge;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic [2:0]    cmd_prot  = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  logic [AW-1:0] m_axil_awaddr;
  logic [2:0]    m_axil_awprot;
  logic          m_axil_awvalid, m_axil_awready;
  logic [DW-1:0] m_axil_wdata;
  logic [SW-1:0] m_axil_wstrb;
  logic          m_axil_wvalid, m_axil_wready;
  logic [1:0]    m_axil_bresp;
  logic          m_axil_bvalid, m_axil_bready;
  logic [AW-1:0] m_axil_araddr;
  logic [2:0]    m_axil_arprot;
  logic          m_axil_arvalid, m_axil_arready;
  logic [DW-1:0] m_axil_rdata;
  logic [1:0]    m_axil_rresp;
  logic          m_axil_rvalid, m_axil_rready;

  always #5 clk = ~clk;

  axil_master_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  // Byte-enable merge: the architectural rule for a strobed write.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- slave RAM with configurable behaviour ----------------
  logic [31:0] slave_mem [16] = '{default: 32'h0};
  int          s_fast = 1, s_aw_dly = 0, s_w_dly = 0, s_b_dly = 0, s_ar_dly = 0, s_r_dly = 0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
  logic        s_rdata_en = 1'b0;
  logic [31:0] s_rdata = 32'h0;
  logic        aw_seen, w_seen, ar_seen;
  int          aw_c, w_c, b_c, ar_c, r_c;
  logic [31:0] sl_awaddr, sl_wdata, sl_araddr;
  logic [3:0]  sl_wstrb;

  always @(posedge clk) begin
    if (rst) begin
      m_axil_awready <= 1'b0; m_axil_wready <= 1'b0; m_axil_bvalid <= 1'b0; m_axil_bresp <= 2'b00;
      m_axil_arready <= 1'b0; m_axil_rvalid <= 1'b0; m_axil_rresp <= 2'b00; m_axil_rdata <= '0;
      aw_seen <= 1'b0; w_seen <= 1'b0; ar_seen <= 1'b0;
      aw_c <= 0; w_c <= 0; b_c <= 0; ar_c <= 0; r_c <= 0;
      sl_awaddr <= '0; sl_wdata <= '0; sl_wstrb <= '0; sl_araddr <= '0;
    end else if (s_fast != 0) begin
      // AW, W and B all presented together, one cycle after the valids.
      m_axil_awready <= m_axil_awvalid && m_axil_wvalid && !m_axil_awready;
      m_axil_wready  <= m_axil_awvalid && m_axil_wvalid && !m_axil_awready;
      m_axil_bvalid  <= m_axil_awvalid && m_axil_wvalid && !m_axil_awready;
      if (m_axil_awvalid && m_axil_wvalid && !m_axil_awready) begin
        m_axil_bresp <= s_bresp;
        slave_mem[m_axil_awaddr[5:2]] <= merge(slave_mem[m_axil_awaddr[5:2]], m_axil_wdata, m_axil_wstrb);
      end
      m_axil_arready <= m_axil_arvalid && !m_axil_arready;
      m_axil_rvalid  <= m_axil_arvalid && !m_axil_arready;
      if (m_axil_arvalid && !m_axil_arready) begin
        m_axil_rresp <= s_rresp;
        m_axil_rdata <= s_rdata_en ? s_rdata : slave_mem[m_axil_araddr[5:2]];
      end
    end else begin
      if (m_axil_awready) m_axil_awready <= 1'b0;
      else if (m_axil_awvalid && !aw_seen) begin
        if (aw_c >= s_aw_dly) begin m_axil_awready <= 1'b1; aw_seen <= 1'b1; aw_c <= 0; sl_awaddr <= m_axil_awaddr; end
        else aw_c <= aw_c + 1;
      end
      if (m_axil_wready) m_axil_wready <= 1'b0;
      else if (m_axil_wvalid && !w_seen) begin
        if (w_c >= s_w_dly) begin
          m_axil_wready <= 1'b1; w_seen <= 1'b1; w_c <= 0; sl_wdata <= m_axil_wdata; sl_wstrb <= m_axil_wstrb;
        end else w_c <= w_c + 1;
      end
      if (m_axil_bvalid) begin
        if (m_axil_bready) begin m_axil_bvalid <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0; end
      end else if (aw_seen && w_seen && !m_axil_awready && !m_axil_wready) begin
        if (b_c >= s_b_dly) begin
          m_axil_bvalid <= 1'b1; m_axil_bresp <= s_bresp; b_c <= 0;
          slave_mem[sl_awaddr[5:2]] <= merge(slave_mem[sl_awaddr[5:2]], sl_wdata, sl_wstrb);
        end else b_c <= b_c + 1;
      end
      if (m_axil_arready) m_axil_arready <= 1'b0;
      else if (m_axil_arvalid && !ar_seen) begin
        if (ar_c >= s_ar_dly) begin m_axil_arready <= 1'b1; ar_seen <= 1'b1; ar_c <= 0; sl_araddr <= m_axil_araddr; end
        else ar_c <= ar_c + 1;
      end
      if (m_axil_rvalid) begin
        if (m_axil_rready) begin m_axil_rvalid <= 1'b0; ar_seen <= 1'b0; end
      end else if (ar_seen && !m_axil_arready) begin
        if (r_c >= s_r_dly) begin
          m_axil_rvalid <= 1'b1; m_axil_rresp <= s_rresp; r_c <= 0;
          m_axil_rdata <= s_rdata_en ? s_rdata : slave_mem[sl_araddr[5:2]];
        end else r_c <= r_c + 1;
      end
    end
  end

  // ---------------- protocol monitor (records events only) ----------------
  int          cyc = 0, viol = 0;
  int          aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
  int          last_aw_cyc = 0, last_w_cyc = 0, last_b_cyc = 0;
  logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
  logic        aw_hs_p = 1'b0, w_hs_p = 1'b0, ar_hs_p = 1'b0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
  logic [3:0]  p_wstrb = '0;
  logic [2:0]  p_awprot = '0, p_arprot = '0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
  logic [3:0]  last_wstrb = '0;
  logic [2:0]  last_awprot = '0, last_arprot = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
      aw_hs_p <= 1'b0; w_hs_p <= 1'b0; ar_hs_p <= 1'b0;
    end else begin
      viol <= viol + (((aw_pend && (!m_axil_awvalid || m_axil_awaddr !== p_awaddr || m_axil_awprot !== p_awprot)) ||
                       (w_pend && (!m_axil_wvalid || m_axil_wdata !== p_wdata || m_axil_wstrb !== p_wstrb)) ||
                       (ar_pend && (!m_axil_arvalid || m_axil_araddr !== p_araddr || m_axil_arprot !== p_arprot)) ||
                       (aw_hs_p && m_axil_awvalid) || (w_hs_p && m_axil_wvalid) || (ar_hs_p && m_axil_arvalid)) ? 1 : 0);
      aw_pend <= m_axil_awvalid && !m_axil_awready;
      w_pend  <= m_axil_wvalid && !m_axil_wready;
      ar_pend <= m_axil_arvalid && !m_axil_arready;
      aw_hs_p <= m_axil_awvalid && m_axil_awready;
      w_hs_p  <= m_axil_wvalid && m_axil_wready;
      ar_hs_p <= m_axil_arvalid && m_axil_arready;
      p_awaddr <= m_axil_awaddr; p_awprot <= m_axil_awprot;
      p_wdata <= m_axil_wdata; p_wstrb <= m_axil_wstrb;
      p_araddr <= m_axil_araddr; p_arprot <= m_axil_arprot;
      if (m_axil_awvalid && m_axil_awready) begin
        aw_n <= aw_n + 1; last_aw_cyc <= cyc; last_awaddr <= m_axil_awaddr; last_awprot <= m_axil_awprot;
      end
      if (m_axil_wvalid && m_axil_wready) begin
        w_n <= w_n + 1; last_w_cyc <= cyc; last_wdata <= m_axil_wdata; last_wstrb <= m_axil_wstrb;
      end
      if (m_axil_bvalid && m_axil_bready) begin b_n <= b_n + 1; last_b_cyc <= cyc; end
      if (m_axil_arvalid && m_axil_arready) begin
        ar_n <= ar_n + 1; last_araddr <= m_axil_araddr; last_arprot <= m_axil_arprot;
      end
      if (m_axil_rvalid && m_axil_rready) r_n <= r_n + 1;
    end
  end

  // ---------------- reference model and driver ----------------
  logic [31:0] exp_mem [16] = '{default: 32'h0};
  int          checks = 0, errors = 0;
  logic [31:0] t_rd;
  logic [1:0]  t_rr;
  int          t_lat, t_rsp_cyc;
  logic        t_bready1, t_rready1;

  task automatic set_slave(input int fast, input int awd, input int wd, input int bd, input int ard, input int rd);
    s_fast = fast; s_aw_dly = awd; s_w_dly = wd; s_b_dly = bd; s_ar_dly = ard; s_r_dly = rd;
  endtask

  task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_prot = p;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    if (w) exp_mem[a[5:2]] = merge(exp_mem[a[5:2]], d, s);
    t_bready1 = m_axil_bready; t_rready1 = m_axil_rready;
    t_lat = 1;
    while (rsp_valid !== 1'b1 && t_lat < 300) begin @(negedge clk); t_lat++; end
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_timeout: rsp_valid=%b required 1 within 300 cycles", rsp_valid); end
    t_rd = rsp_rdata; t_rr = rsp_resp; t_rsp_cyc = cyc;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready} !== 5'b0) begin
      errors++; $display("FAIL reset_axi: aw/w/ar valid,b/r ready=%b required 00000",
                         {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready});
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
      errors++; $display("FAIL reset_rsp: valid=%b rdata=%h resp=%b required 0/0/0", rsp_valid, rsp_rdata, rsp_resp);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_write_basic();
    int aw0, w0, b0;
    set_slave(1, 0, 0, 0, 0, 0);
    aw0 = aw_n; w0 = w_n; b0 = b_n;
    do_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010);
    checks++;
    if (t_lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d required 3", t_lat); end
    checks++;
    if (t_rr !== 2'b00 || t_rd !== 32'h0) begin errors++; $display("FAIL wr_rsp: resp=%b rdata=%h required 00/0", t_rr, t_rd); end
    checks++;
    if (aw_n - aw0 != 1 || w_n - w0 != 1 || b_n - b0 != 1) begin
      errors++; $display("FAIL wr_hs_count: aw=%0d w=%0d b=%0d required 1/1/1", aw_n - aw0, w_n - w0, b_n - b0);
    end
    checks++;
    if (last_awaddr !== 32'h10 || last_awprot !== 3'b010) begin
      errors++; $display("FAIL wr_aw_fields: addr=%h prot=%b required 10/010", last_awaddr, last_awprot);
    end
    checks++;
    if (last_wdata !== 32'hDEADBEEF || last_wstrb !== 4'hF) begin
      errors++; $display("FAIL wr_w_fields: data=%h strb=%h required deadbeef/f", last_wdata, last_wstrb);
    end
    checks++;
    if (t_bready1 !== 1'b1) begin errors++; $display("FAIL wr_bready: got %b required 1", t_bready1); end
  endtask

  task automatic test_read_basic();
    int ar0;
    set_slave(1, 0, 0, 0, 0, 0);
    ar0 = ar_n;
    do_cmd(1'b0, 32'h10, 32'h0, 4'h0, 3'b101);
    checks++;
    if (t_rd !== exp_mem[4] || t_rr !== 2'b00) begin
      errors++; $display("FAIL rd_data: rdata=%h resp=%b required %h/00", t_rd, t_rr, exp_mem[4]);
    end
    checks++;
    if (t_lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d required 3", t_lat); end
    checks++;
    if (ar_n - ar0 != 1 || last_araddr !== 32'h10 || last_arprot !== 3'b101) begin
      errors++; $display("FAIL rd_ar: count=%0d addr=%h prot=%b required 1/10/101", ar_n - ar0, last_araddr, last_arprot);
    end
    checks++;
    if (t_rready1 !== 1'b1) begin errors++; $display("FAIL rd_rready: got %b required 1", t_rready1); end
    do_cmd(1'b1, 32'h10, 32'h00005500, 4'h2, 3'b000);
    do_cmd(1'b0, 32'h10, 32'h0, 4'h0, 3'b000);
    checks++;
    if (t_rd !== exp_mem[4]) begin errors++; $display("FAIL rd_partial: got %h required %h", t_rd, exp_mem[4]); end
  endtask

  task automatic test_skew();
    int aw0, w0, b0;
    // W accepted 5 cycles after AW, then the reverse, then everything together.
    for (int k = 0; k < 3; k++) begin
      if (k == 0) set_slave(0, 0, 5, 0, 0, 0);
      else if (k == 1) set_slave(0, 5, 0, 0, 0, 0);
      else set_slave(1, 0, 0, 0, 0, 0);
      aw0 = aw_n; w0 = w_n; b0 = b_n;
      do_cmd(1'b1, 32'h20 + 32'(4 * k), 32'hA5A50000 + 32'(k), 4'hF, 3'b000);
      checks++;
      if (aw_n - aw0 != 1 || w_n - w0 != 1 || b_n - b0 != 1) begin
        errors++; $display("FAIL skew%0d_hs: aw=%0d w=%0d b=%0d required 1/1/1", k, aw_n - aw0, w_n - w0, b_n - b0);
      end
      checks++;
      if (!(t_rsp_cyc > last_b_cyc)) begin
        errors++; $display("FAIL skew%0d_order: rsp cycle %0d required after B cycle %0d", k, t_rsp_cyc, last_b_cyc);
      end
      checks++;
      if ((k == 0 && last_w_cyc - last_aw_cyc < 5) || (k == 1 && last_aw_cyc - last_w_cyc < 5) ||
          (k == 2 && last_w_cyc != last_aw_cyc)) begin
        errors++; $display("FAIL skew%0d_gap: aw cycle %0d w cycle %0d", k, last_aw_cyc, last_w_cyc);
      end
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++; $display("FAIL skew%0d_single_rsp: rsp_valid=%b cmd_ready=%b required 0/1", k, rsp_valid, cmd_ready);
      end
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL skew_protocol: violations=%0d required 0", viol); end
  endtask

  task automatic test_errors();
    set_slave(1, 0, 0, 0, 0, 0);
    s_rdata_en = 1'b1; s_rdata = 32'h1234; s_rresp = 2'b10;
    do_cmd(1'b0, 32'h30, 32'h0, 4'h0, 3'b000);
    s_rdata_en = 1'b0; s_rresp = 2'b00;
    checks++;
    if (t_rd !== 32'h1234 || t_rr !== 2'b10) begin
      errors++; $display("FAIL rd_slverr: rdata=%h resp=%b required 1234/10", t_rd, t_rr);
    end
    s_bresp = 2'b11;
    do_cmd(1'b1, 32'h34, 32'h0BADF00D, 4'hF, 3'b000);
    s_bresp = 2'b00;
    checks++;
    if (t_rr !== 2'b11 || t_rd !== 32'h0) begin
      errors++; $display("FAIL wr_decerr: resp=%b rdata=%h required 11/0", t_rr, t_rd);
    end
  endtask

  task automatic test_random();
    logic        w;
    logic [3:0]  idx, s;
    logic [31:0] d, exp_d;
    int          nerr;
    nerr = 0;
    for (int i = 0; i < 40; i++) begin
      set_slave(($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      w = 1'($urandom_range(0, 1)); idx = 4'($urandom_range(0, 15));
      d = $urandom; s = 4'($urandom_range(0, 15));
      exp_d = w ? 32'h0 : exp_mem[idx];
      do_cmd(w, {26'h0, idx, 2'b00}, d, s, 3'($urandom_range(0, 7)));
      checks++;
      if (t_rd !== exp_d || t_rr !== 2'b00) begin
        errors++; nerr++;
        if (nerr < 5) $display("FAIL random%0d: write=%b idx=%0d rdata=%h resp=%b required %h/00", i, w, idx, t_rd, t_rr, exp_d);
      end
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL random_protocol: violations=%0d required 0", viol); end
  endtask

  task automatic test_stall();
    int          n, ar0;
    logic [31:0] hold_d;
    logic [1:0]  hold_r;
    set_slave(1, 0, 0, 0, 0, 0);
    ar0 = ar_n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; cmd_prot = 3'b000;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_addr = 32'h14;   // next command stays presented throughout
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    hold_d = rsp_rdata; hold_r = rsp_resp;
    checks++;
    if (hold_d !== exp_mem[4] || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL stall_first: rdata=%h valid=%b required %h/1", hold_d, rsp_valid, exp_mem[4]);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== hold_d || rsp_resp !== hold_r || cmd_ready !== 1'b0 ||
          m_axil_arvalid !== 1'b0 || m_axil_awvalid !== 1'b0 || m_axil_wvalid !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: rsp_valid=%b rdata=%h cmd_ready=%b arvalid=%b awvalid=%b required 1/%h/0/0/0",
                           i, rsp_valid, rsp_rdata, cmd_ready, m_axil_arvalid, m_axil_awvalid, hold_d);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release: cmd_ready=%b rsp_valid=%b required 1/0", cmd_ready, rsp_valid);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (m_axil_arvalid !== 1'b1 || m_axil_araddr !== 32'h14 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL stall_next_accept: arvalid=%b araddr=%h cmd_ready=%b required 1/14/0",
                         m_axil_arvalid, m_axil_araddr, cmd_ready);
    end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp_mem[5] || ar_n - ar0 != 2) begin
      errors++; $display("FAIL stall_next_rsp: valid=%b rdata=%h ar_count=%0d required 1/%h/2",
                         rsp_valid, rsp_rdata, ar_n - ar0, exp_mem[5]);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    set_slave(0, 5, 5, 0, 0, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h18; cmd_wdata = 32'h11223344; cmd_wstrb = 4'hF;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (m_axil_awvalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: awvalid=%b required 1", m_axil_awvalid); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, rsp_valid} !== 4'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_post: aw/w/ar/rsp valid=%b cmd_ready=%b required 0000/1",
                         {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, rsp_valid}, cmd_ready);
    end
    set_slave(1, 0, 0, 0, 0, 0);
    do_cmd(1'b0, 32'h18, 32'h0, 4'h0, 3'b000);
    checks++;
    if (t_rd !== exp_mem[6] || t_rr !== 2'b00 || t_lat !== 3) begin
      errors++; $display("FAIL rstmid_read: rdata=%h resp=%b lat=%0d required %h/00/3", t_rd, t_rr, t_lat, exp_mem[6]);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_skew();
    test_errors();
    test_random();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axil_master_bridge.md
# axil_master_bridge

Single-outstanding AXI4-Lite master that turns a simple valid/ready command/response port into AXI4-Lite read and write transactions. It sits between a simple request source (CPU load/store unit, DMA sequencer, test driver) and the AXI4-Lite interconnect or slave RAM. It issues one transaction at a time and returns its data/response on a separate response channel.

## Interface
- DATA_WIDTH, 32, data bus width in bits (multiple of 8)
- ADDR_WIDTH, 32, address width in bits
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address, passed unmodified
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- cmd_wstrb  in  STRB_WIDTH  write byte enables (ignored for reads)
- cmd_prot  in  3  AXI prot value for AW or AR
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data; all-zero for writes
- rsp_resp  out  2  captured BRESP or RRESP
- m_axil_aw{addr,prot,valid}/awready, m_axil_w{data,strb,valid}/wready, m_axil_b{resp,valid}/bready, m_axil_ar{addr,prot,valid}/arready, m_axil_r{data,resp,valid}/rready  standard AXI4-Lite master ports, widths ADDR_WIDTH/3/DATA_WIDTH/STRB_WIDTH/2

## Operation
- States: IDLE, WRITE, READ, RESP.
- IDLE: cmd_ready=1. On accept, register addr/data/strb/prot. cmd_write=1: go to WRITE, set awvalid=wvalid=1. cmd_write=0: go to READ, set arvalid=1.
- WRITE: awvalid and wvalid drop independently the cycle after their own handshake. Sticky flags aw_done, w_done, b_done. bready=1 for the whole state. A B beat arriving in the same cycle as the AW/W handshakes is accepted. Capture bresp on B handshake. Leave for RESP when all three flags are set (counting handshakes completing this cycle).
- READ: arvalid drops after the AR handshake. rready=1 for the whole state. An R beat in the same cycle as AR handshake is accepted. Capture rdata/rresp. Leave for RESP once AR and R are both done.
- RESP: rsp_valid=1. rsp_rdata/rsp_resp are held stable. On rsp_ready go to IDLE. cmd_ready=0 in every state except IDLE.
- AXI address/data/strb/prot outputs are registers. They stay stable while the corresponding valid is high. A valid is never deasserted before its handshake.
- SLVERR/DECERR responses are forwarded unchanged. The block never generates errors itself.
- Exactly one transaction is outstanding. No reordering and no combining.

## Timing
- Reset values: awvalid=wvalid=arvalid=0, bready=rready=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, state=IDLE (cmd_ready=1 from the first cycle after reset).
- Reset mid-transaction: the transaction is abandoned and all valids drop on the next edge. The slave shares rst.
- Command accepted at edge N: AXI valids are high from cycle N+1.
- Against a slave that asserts ready and B/R one cycle after valid: handshakes complete in cycle N+2, rsp_valid is high in cycle N+3. Best-case command-to-response is 3 cycles.
- Throughput: at most one command per 4 cycles (accept, issue, complete, respond).
- rsp_ready held low: remain in RESP indefinitely with cmd_ready=0.
- awready before wready, wready before awready, or both together: all are legal. The response is produced only after both handshakes and B.
- cmd_valid while not in IDLE: ignored, not accepted.

## Test plan
- Write addr=0x0000_0010, wdata=0xDEADBEEF, wstrb=0xF, single-cycle-ready slave -> one AW and one W handshake with those values, bready high, rsp_valid 3 cycles after accept with rsp_resp=0, rsp_rdata=0.
- Read back 0x10 -> one AR handshake at 0x10, rsp_rdata=0xDEADBEEF, rsp_resp=0; partial write wstrb=0x2 data=0x0000_5500 then read -> 0xDEAD55EF.
- Slave delays wready 5 cycles after awready (and the reverse) -> awvalid drops right after its handshake, wvalid stays high until its handshake, rsp_valid only after B; then the same with AW/W/B all in one cycle -> single response.
- Slave returns rresp=2'b10 with rdata=0x1234 -> rsp_resp=2'b10, rsp_rdata=0x1234; bresp=2'b11 on a write -> rsp_resp=2'b11.
- rsp_ready held low 10 cycles with cmd_valid high -> rsp_valid and data stable, cmd_ready=0, no new AXI valid; on release the next command is accepted the following cycle.
- Assert rst while awvalid is high -> all valids and rsp_valid are 0 after the edge, cmd_ready=1, and the next read completes normally.
